// File: rtl/player_attack.sv
`default_nettype none
// ============================================================================
// Module      : player_attack
// Description : Two independent per-player attack sequencers
//               (IDLE -> WINDUP -> STRIKE -> RECOVER) with registered strike
//               window, animation code, busy flag and saturating strike count.
//               Optional macro ATTACK_BUFFER_EN buffers one press made during
//               RECOVER so the next attack begins without an IDLE cycle.
// Revision    : 1.0 - initial release
// ============================================================================

module player_attack_ch #(
    parameter int WINDUP_LEN   = 4,
    parameter int STRIKE_LEN   = 6,
    parameter int COOLDOWN_LEN = 8
) (
    input  logic       frame_clk,
    input  logic       RESET,
    input  logic       atk_key_i,
    input  logic       alive_i,
    output logic       fight_o,
    output logic [1:0] atk_frame_o,
    output logic       atk_busy_o,
    output logic [7:0] atk_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WINDUP  = 2'd1,
        ST_STRIKE  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic [5:0] c_WINDUP_LAST   = 6'(WINDUP_LEN - 1);
    localparam logic [5:0] c_STRIKE_LAST   = 6'(STRIKE_LEN - 1);
    localparam logic [5:0] c_COOLDOWN_LAST = 6'(COOLDOWN_LEN - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] count_q, count_d;
    logic       key_q;
    logic       fight_q;
    logic [1:0] frame_q;
    logic       busy_q;
    logic       press;

`ifdef ATTACK_BUFFER_EN
    logic       pending_q, pending_d;
`endif

    assign press = atk_key_i & ~key_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
`ifdef ATTACK_BUFFER_EN
        pending_d = pending_q;
`endif
        if (!alive_i) begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
`ifdef ATTACK_BUFFER_EN
            pending_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press) begin
                        state_d = ST_WINDUP;
                        cnt_d   = 6'd0;
                    end
                end
                ST_WINDUP: begin
                    if (cnt_q == c_WINDUP_LAST) begin
                        state_d = ST_STRIKE;
                        cnt_d   = 6'd0;
                        if (count_q != 8'hFF) begin
                            count_d = count_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_STRIKE: begin
                    if (cnt_q == c_STRIKE_LAST) begin
                        state_d = ST_RECOVER;
                        cnt_d   = 6'd0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_q == c_COOLDOWN_LAST) begin
                        cnt_d   = 6'd0;
                        state_d = ST_IDLE;
`ifdef ATTACK_BUFFER_EN
                        // A press landing on the final RECOVER cycle also chains.
                        if (pending_q | press) begin
                            state_d   = ST_WINDUP;
                            pending_d = 1'b0;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + 6'd1;
`ifdef ATTACK_BUFFER_EN
                        if (press) begin
                            pending_d = 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 6'd0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge frame_clk) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            count_q <= 8'd0;
            key_q   <= 1'b1;
            fight_q <= 1'b0;
            frame_q <= 2'd0;
            busy_q  <= 1'b0;
`ifdef ATTACK_BUFFER_EN
            pending_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            key_q   <= atk_key_i;
            fight_q <= (state_d == ST_STRIKE);
            frame_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
`ifdef ATTACK_BUFFER_EN
            pending_q <= pending_d;
`endif
        end
    end

    assign fight_o     = fight_q;
    assign atk_frame_o = frame_q;
    assign atk_busy_o  = busy_q;
    assign atk_count_o = count_q;

endmodule

module player_attack #(
    parameter int WINDUP_LEN   = 4,
    parameter int STRIKE_LEN   = 6,
    parameter int COOLDOWN_LEN = 8
) (
    input  logic            frame_clk,
    input  logic            RESET,
    input  logic [1:0]      atk_key,
    input  logic [1:0]      alive,
    output logic [1:0]      fight,
    output logic [1:0][1:0] atk_frame,
    output logic [1:0]      atk_busy,
    output logic [1:0][7:0] atk_count
);

    for (genvar i = 0; i < 2; i++) begin : g_ch
        player_attack_ch #(
            .WINDUP_LEN   (WINDUP_LEN),
            .STRIKE_LEN   (STRIKE_LEN),
            .COOLDOWN_LEN (COOLDOWN_LEN)
        ) u_ch (
            .frame_clk   (frame_clk),
            .RESET       (RESET),
            .atk_key_i   (atk_key[i]),
            .alive_i     (alive[i]),
            .fight_o     (fight[i]),
            .atk_frame_o (atk_frame[i]),
            .atk_busy_o  (atk_busy[i]),
            .atk_count_o (atk_count[i])
        );
    end

endmodule

`default_nettype wire

// File: doc/player_attack.md
PLAYER_ATTACK -- requirements
Module: player_attack

Interface
REQ-001 Parameter WINDUP_LEN, default 4, WINDUP duration in frame_clk cycles (legal 1..63).
REQ-002 Parameter STRIKE_LEN, default 6, STRIKE duration in cycles (legal 1..63).
REQ-003 Parameter COOLDOWN_LEN, default 8, RECOVER duration in cycles (legal 1..63).
REQ-004 frame_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 atk_key[2]  input  1 each  per-player attack key level; 1 = pressed.
REQ-007 alive[2]  input  1 each  per-player enable; 0 = player cannot attack.
REQ-008 fight[2]  output  1 each  registered strike window; feeds slim kill logic as fight[0]/fight[1].
REQ-009 atk_frame[2]  output  2 each  registered animation code: 0 IDLE, 1 WINDUP, 2 STRIKE, 3 RECOVER.
REQ-010 atk_busy[2]  output  1 each  registered; 1 when state is not IDLE.
REQ-011 atk_count[2]  output  8 each  registered count of strikes started, saturating.

Function
REQ-012 Two identical, fully independent channels (player 0, player 1) SHALL be provided; no cross-channel interaction.
REQ-013 Each channel SHALL register atk_key into key_q every cycle; press edge = atk_key & ~key_q.
REQ-014 FSM states SHALL be IDLE, WINDUP, STRIKE, RECOVER with a 6-bit phase counter cnt.
REQ-015 IDLE: press edge with alive=1 -> WINDUP, cnt=0; otherwise stay.
REQ-016 WINDUP: cnt==WINDUP_LEN-1 -> STRIKE, cnt=0; else cnt+1.
REQ-017 STRIKE: cnt==STRIKE_LEN-1 -> RECOVER, cnt=0; else cnt+1.
REQ-018 RECOVER: cnt==COOLDOWN_LEN-1 -> IDLE, cnt=0; else cnt+1.
REQ-019 Timing: edge sampled at clock k -> WINDUP after k; fight=1 for exactly STRIKE_LEN cycles starting after k+WINDUP_LEN; IDLE after k+WINDUP_LEN+STRIKE_LEN+COOLDOWN_LEN.
REQ-020 fight SHALL be 1 iff state==STRIKE; no glitch, registered output.
REQ-021 atk_frame and atk_busy SHALL reflect the current state with zero added latency relative to state.
REQ-022 Press edges in WINDUP or STRIKE SHALL be ignored; a key held continuously SHALL NOT retrigger.
REQ-023 atk_count SHALL increment on the WINDUP->STRIKE transition and hold at 255 (no wrap).
REQ-024 alive=0 in any state SHALL force IDLE, cnt=0, and clear any pending press on the next edge; fight drops that edge.
REQ-025 Simultaneous alive=0 and press edge: alive wins, no attack starts.

Reset
REQ-026 RESET=1 at a clock edge SHALL force, per channel: state IDLE, cnt 0, fight 0, atk_frame 0, atk_busy 0, atk_count 0, pending 0.
REQ-027 key_q SHALL reset to 1 so a key held across reset release produces no press edge.
REQ-028 RESET mid-attack SHALL abort immediately; fight is 0 from the first cycle after the reset edge.

Configuration
REQ-029 Macro ATTACK_BUFFER_EN defined: a press edge in RECOVER SHALL set a 1-bit pending flag; at RECOVER end with pending=1 go directly to WINDUP (cnt=0, pending cleared) instead of IDLE.
REQ-030 Macro ATTACK_BUFFER_EN undefined: no pending flag exists; press edges in RECOVER are dropped; RECOVER always ends in IDLE.
REQ-031 Multiple press edges in one RECOVER SHALL buffer at most one attack.

Verification
REQ-032 Defaults, reset, atk_key[0] 0->1 sampled at edge 10 -> fight[0]=1 after edges 14..19 (6 cycles), atk_frame[0]=3 after 20..27, IDLE after 28, atk_count[0]=1.
REQ-033 Key held high 100 cycles -> exactly one strike, atk_count=1; player 1 outputs stay 0.
REQ-034 Press edge during STRIKE and another during RECOVER -> without ATTACK_BUFFER_EN one strike only; with it, second WINDUP starts right after RECOVER, no IDLE cycle.
REQ-035 alive[1]=0 asserted during STRIKE -> fight[1]=0 and atk_frame[1]=0 after the next edge; pending cleared.
REQ-036 RESET pulsed during WINDUP with key held -> all outputs 0, no attack after release until key released and re-pressed.
REQ-037 256 strikes on player 0 -> atk_count[0]=255 after strikes 255 and 256.
